// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared opcodes, FSM states and helpers for the MDU sequencer
// Purpose: common definitions used by mdu_ctrl and mdu_arith.
// Ports: none (package).
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ops that occupy the unit for several cycles and raise busy.
    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide result generator
// Purpose: produce the HI/LO values a MULT/MULTU/DIV/DIVU would write.
// Ports:
//   op    in  4   MDU opcode
//   rs    in  32  operand A (multiplicand / dividend)
//   rt    in  32  operand B (multiplier / divisor)
//   hi_n  out 32  product high word or remainder
//   lo_n  out 32  product low word or quotient
//   div0  out 1   divide op with zero divisor (result must not be committed)
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] q_u;
    logic [31:0] r_u;

    always_comb begin
        prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        prod_u = {32'd0, rs} * {32'd0, rt};

        div0  = ((op == OP_DIV) || (op == OP_DIVU)) && (rt == 32'd0);

        // Signed divide runs on magnitudes; signs are reapplied afterwards so the
        // quotient truncates toward zero and the remainder follows the dividend.
        // 0x80000000 / -1 falls out as 0x80000000 rem 0 without a special case.
        neg_a = (op == OP_DIV) && rs[31];
        neg_b = (op == OP_DIV) && rt[31];
        mag_a = neg_a ? -rs : rs;
        mag_b = neg_b ? -rt : rt;
        // Divisor forced nonzero to keep the operator defined; div0 suppresses the commit.
        div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
        q_u   = mag_a / div_b;
        r_u   = mag_a % div_b;

        hi_n = 32'd0;
        lo_n = 32'd0;
        case (op)
            OP_MULT:  {hi_n, lo_n} = prod_s;
            OP_MULTU: {hi_n, lo_n} = prod_u;
            OP_DIV, OP_DIVU: begin
                lo_n = (neg_a ^ neg_b) ? -q_u : q_u;
                hi_n = neg_a ? -r_u : r_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - E-stage multiply/divide sequencer owning HI/LO
// Purpose: accept MDU ops, model fixed MUL/DIV latency, own HI/LO, drive stall.
// Ports:
//   clk, reset  in   clock, synchronous active-high reset
//   req         in   exception/interrupt flush of the current E-stage op
//   start       in   E stage holds a valid MDU instruction
//   op          in   4   MDU opcode
//   rs, rt      in   32  operands (rs is also the MTHI/MTLO source)
//   d_is_md     in   D-stage instruction is an MDU op
//   busy        out  multi-cycle op in flight
//   stall       out  hold D while an MDU op is pending or starting
//   rdata       out  32  HI for MFHI, otherwise LO
//   hi, lo      out  32  architectural HI/LO
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi_q;
    logic [31:0]      pend_lo_q;
    logic             pend_div0_q;

    logic [31:0]      hi_n;
    logic [31:0]      lo_n;
    logic             div0;
    logic             accept;

    mdu_arith u_arith (
        .op   (op),
        .rs   (rs),
        .rt   (rt),
        .hi_n (hi_n),
        .lo_n (lo_n),
        .div0 (div0)
    );

    // A flushed op (req) never starts; an op arriving while RUN is dropped.
    assign accept = start & ~req & (state_q == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            pend_hi_q   <= 32'd0;
            pend_lo_q   <= 32'd0;
            pend_div0_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (accept) begin
                if (is_multicycle(op)) begin
                    pend_hi_q   <= hi_n;
                    pend_lo_q   <= lo_n;
                    pend_div0_q <= div0;
                    cnt_q       <= ((op == OP_MULT) || (op == OP_MULTU)) ?
                                   CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
                    busy_q      <= 1'b1;
                    state_q     <= ST_RUN;
                end else if (op == OP_MTHI) begin
                    hi_q <= rs;
                end else if (op == OP_MTLO) begin
                    lo_q <= rs;
                end
            end
        end else begin
            // req is ignored here: the running op belongs to an older instruction.
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
                if (!pend_div0_q) begin
                    hi_q <= pend_hi_q;
                    lo_q <= pend_lo_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(start && !req && state_q == ST_RUN))
                else $error("mdu_ctrl: MDU op issued while busy");
        end
    end

    assign busy  = busy_q;
    assign stall = d_is_md & (busy_q | (start & is_multicycle(op)));
    assign rdata = (op == OP_MFHI) ? hi_q : lo_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .op(op),
        .rs(rs), .rt(rt), .d_is_md(d_is_md), .busy(busy), .stall(stall),
        .rdata(rdata), .hi(hi), .lo(lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [3:0] o);
        if (o == OP_MULT || o == OP_MULTU) return MUL_LAT;
        if (o == OP_DIV || o == OP_DIVU) return DIV_LAT;
        return 0;
    endfunction

    // Architectural effect of an accepted op, from plain 64-bit arithmetic.
    function automatic void model_exec(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] pu;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        case (o)
            OP_MULT: begin
                q = sa * sb;
                m_hi = q[63:32];
                m_lo = q[31:0];
            end
            OP_MULTU: begin
                pu = 64'(a) * 64'(b);
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            OP_DIV: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            OP_DIVU: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic flush);
        op = o; rs = a; rt = b; req = flush; start = 1'b1;
        tick();
        start = 1'b0; req = 1'b0; op = OP_NONE;
        if (!flush) model_exec(o, a, b);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    endtask

    task automatic test_mult();
        int n;
        issue(OP_MULT, -32'sd3, 32'd7, 1'b0);
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL mult_lo_early got=%h exp=0", lo); end
        wait_idle(n);
        checks++; if (n != MUL_LAT) begin errors++; $display("FAIL mult_lat got=%0d exp=%0d", n, MUL_LAT); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo); end
    endtask

    task automatic test_divu();
        int n;
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
        wait_idle(n);
        checks++; if (n != DIV_LAT) begin errors++; $display("FAIL divu_lat got=%0d exp=%0d", n, DIV_LAT); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got=%h exp=e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got=%h exp=2", hi); end
    endtask

    task automatic test_div_overflow();
        int n;
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_idle(n);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL divovf_hi got=%h exp=0", hi); end
    endtask

    task automatic test_div_zero();
        int n;
        issue(OP_MTHI, 32'h55, 32'd0, 1'b0);
        issue(OP_MTLO, 32'h55, 32'd0, 1'b0);
        issue(OP_DIV, 32'd123, 32'd0, 1'b0);
        wait_idle(n);
        checks++; if (n != DIV_LAT) begin errors++; $display("FAIL div0_lat got=%0d exp=%0d", n, DIV_LAT); end
        checks++; if (hi !== 32'h55) begin errors++; $display("FAIL div0_hi got=%h exp=55", hi); end
        checks++; if (lo !== 32'h55) begin errors++; $display("FAIL div0_lo got=%h exp=55", lo); end
    endtask

    task automatic test_flush();
        int n;
        issue(OP_MULT, 32'd9, 32'd9, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
        wait_idle(n);
        issue(OP_MTLO, 32'hDEAD, 32'd0, 1'b1);
        tick();
        checks++; if (hi !== m_hi) begin errors++; $display("FAIL flush_hi got=%h exp=%h", hi, m_hi); end
        checks++; if (lo !== m_lo) begin errors++; $display("FAIL flush_lo got=%h exp=%h", lo, m_lo); end
    endtask

    task automatic test_req_during_run();
        int n;
        issue(OP_DIV, 32'd1000, -32'sd3, 1'b0);
        tick(); tick();
        req = 1'b1;
        tick(); tick(); tick();
        req = 1'b0;
        wait_idle(n);
        checks++; if (n + 5 != DIV_LAT) begin errors++; $display("FAIL reqrun_lat got=%0d exp=%0d", n + 5, DIV_LAT); end
        checks++; if (lo !== 32'hFFFFFEB3) begin errors++; $display("FAIL reqrun_lo got=%h exp=fffffeb3", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL reqrun_hi got=%h exp=1", hi); end
    endtask

    task automatic test_stall();
        int n;
        int guard;
        d_is_md = 1'b1;
        op = OP_MTHI; rs = 32'd0; start = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_mt got=%b exp=0", stall); end
        start = 1'b0;
        op = OP_DIV; rs = 32'd50; rt = 32'd5; start = 1'b1;
        #1;
        n = 0;
        if (stall === 1'b1) n++;
        tick();
        start = 1'b0; op = OP_NONE;
        model_exec(OP_DIV, 32'd50, 32'd5);
        #1;
        guard = 0;
        while (busy === 1'b1 && guard < 100) begin
            if (stall === 1'b1) n++;
            guard++;
            tick();
            #1;
        end
        checks++; if (n != DIV_LAT + 1) begin errors++; $display("FAIL stall_cycles got=%0d exp=%0d", n, DIV_LAT + 1); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_after got=%b exp=0", stall); end
        d_is_md = 1'b0;
        checks++; if (lo !== 32'd10) begin errors++; $display("FAIL stall_div_lo got=%h exp=a", lo); end
    endtask

    task automatic test_mt_mf();
        issue(OP_MTLO, 32'h1234, 32'd0, 1'b0);
        checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL mtlo got=%h exp=1234", lo); end
        op = OP_MFLO;
        #1;
        checks++; if (rdata !== 32'h1234) begin errors++; $display("FAIL mflo got=%h exp=1234", rdata); end
        op = OP_MFHI;
        #1;
        checks++; if (rdata !== m_hi) begin errors++; $display("FAIL mfhi got=%h exp=%h", rdata, m_hi); end
        op = OP_NONE;
    endtask

    task automatic test_reset_mid();
        issue(OP_MULT, 32'd1000, 32'd1000, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        tick(); tick(); tick(); tick();
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rstmid_lo got=%h exp=0", lo); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        wait_idle(n);
        checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'd1) begin errors++; $display("FAIL b2b_multu got=%h_%h exp=fffffffe_00000001", hi, lo); end
        issue(OP_DIVU, 32'hFFFFFFFF, 32'd16, 1'b0);
        wait_idle(n);
        checks++; if (n != DIV_LAT) begin errors++; $display("FAIL b2b_lat got=%0d exp=%0d", n, DIV_LAT); end
        checks++; if (lo !== 32'h0FFFFFFF || hi !== 32'hF) begin errors++; $display("FAIL b2b_divu got=%h_%h exp=0000000f_0fffffff", hi, lo); end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [6];
        specials = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd7};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic test_random();
        int n;
        logic [3:0]  o;
        logic [31:0] a, b;
        logic        f;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 8));
            a = pick_operand();
            b = pick_operand();
            f = ($urandom_range(0, 4) == 0);
            op = o; rs = a; rt = b; req = f; start = 1'b1;
            #1;
            if (o == OP_MFHI || o == OP_MFLO) begin
                checks++;
                if (rdata !== ((o == OP_MFHI) ? m_hi : m_lo)) begin
                    errors++;
                    $display("FAIL rand_mf[%0d] got=%h exp=%h", i, rdata, (o == OP_MFHI) ? m_hi : m_lo);
                end
            end
            tick();
            start = 1'b0; req = 1'b0; op = OP_NONE;
            if (!f) model_exec(o, a, b);
            wait_idle(n);
            checks++;
            if (n != (f ? 0 : exp_lat(o))) begin
                errors++;
                $display("FAIL rand_lat[%0d] op=%0d got=%0d exp=%0d", i, o, n, f ? 0 : exp_lat(o));
            end
            checks++;
            if (hi !== m_hi || lo !== m_lo) begin
                errors++;
                $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, o, a, b, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; start = 1'b0; op = OP_NONE;
        rs = 32'd0; rt = 32'd0; d_is_md = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        test_reset();
        test_mult();
        test_divu();
        test_div_overflow();
        test_div_zero();
        test_flush();
        test_req_during_run();
        test_stall();
        test_mt_mf();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
